// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - func3 encodings, port indices and FSM state type for the data-memory arbiter
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } arb_state_t;

    // Unsigned access types only make sense for loads.
    function automatic logic func3_ok(input logic [2:0] f3, input logic we);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = !we;
            default:             ok = 1'b0;
        endcase
        func3_ok = ok;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - two-port request/response and shared-memory signal bundle
interface dmem_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][2:0]  req_func3;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic [2:0]       mem_func3;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_wen;
    logic [31:0]      mem_rdata;

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_func3, mem_addr, mem_wdata, mem_wen
    );

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_func3, mem_addr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/dmem_load_ext.sv
// rtl/dmem_load_ext.sv - sign/zero extension of raw memory words for byte and half loads
module dmem_load_ext import dmem_pkg::*; (
    input  logic [2:0]  func3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);
    always_comb begin
        ext = raw;
        case (func3)
            F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  ext = {24'h0, raw[7:0]};
            F3_LHU:  ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter for a shared data memory; DMEM_ARB_RR_EN selects round-robin over fixed priority
module dmem_arbiter import dmem_pkg::*; #(
    parameter int ADDR_W = 24
) (
    input  logic    clk,
    input  logic    rst,
    dmem_if.slave   bus
);
    arb_state_t  state;
    logic        cur_port;
    logic        cur_we;
    logic [2:0]  cur_func3;
    logic        gnt_port;
    logic        any_valid;
    logic        req_legal;
    logic [31:0] ext_data;

    assign any_valid = |bus.req_valid;

`ifdef DMEM_ARB_RR_EN
    logic last_gnt;

    assign gnt_port = (&bus.req_valid) ? ~last_gnt : ~bus.req_valid[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= PORT_LDR;
        end else if (state == S_IDLE && any_valid) begin
            last_gnt <= gnt_port;
        end
    end
`else
    assign gnt_port = bus.req_valid[0] ? PORT_CPU : PORT_LDR;
`endif

    // Ready is combinational so a request can be taken in the cycle a response leaves.
    assign bus.req_ready = (state == S_IDLE && any_valid && !rst) ? (2'b01 << gnt_port) : 2'b00;

    assign req_legal = func3_ok(bus.req_func3[gnt_port], bus.req_we[gnt_port])
                    && ((bus.req_addr[gnt_port] >> ADDR_W) == 32'd0);

    dmem_load_ext u_ext (
        .func3 (cur_func3),
        .raw   (bus.mem_rdata),
        .ext   (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cur_port       <= PORT_CPU;
            cur_we         <= 1'b0;
            cur_func3      <= '0;
            bus.resp_valid <= '0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_wen    <= 1'b0;
            bus.mem_func3  <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.resp_valid <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_wen    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        cur_port  <= gnt_port;
                        cur_we    <= bus.req_we[gnt_port];
                        cur_func3 <= bus.req_func3[gnt_port];
                        if (req_legal) begin
                            // Memory outputs are loaded here so they are stable throughout ISSUE.
                            bus.mem_addr  <= bus.req_addr[gnt_port];
                            bus.mem_wdata <= bus.req_wdata[gnt_port];
                            bus.mem_func3 <= {1'b0, bus.req_func3[gnt_port][1:0]};
                            bus.mem_wen   <= bus.req_we[gnt_port];
                            state         <= S_ISSUE;
                        end else begin
                            bus.resp_valid <= 2'b01 << gnt_port;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    bus.resp_valid <= 2'b01 << cur_port;
                    bus.resp_rdata <= cur_we ? 32'h0 : ext_data;
                    state          <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter: directed table, corner sequences, random traffic vs reference model
module tb_dmem_arbiter;
    import dmem_pkg::*;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    int   vec  = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    dmem_if bus();

    dmem_arbiter #(.ADDR_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory behind the arbiter: byte-lane merge on write, registered read.
    logic [31:0] dmem [1024];

    function automatic logic [31:0] lane_merge(input logic [2:0] f3, input logic [31:0] old, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   lane_merge = {old[31:8], wd[7:0]};
            2'b01:   lane_merge = {old[31:16], wd[15:0]};
            default: lane_merge = wd;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= '0;
            bus.mem_rdata <= '0;
        end else begin
            if (bus.mem_wen)
                dmem[bus.mem_addr[9:0]] <= lane_merge(bus.mem_func3, dmem[bus.mem_addr[9:0]], bus.mem_wdata);
            bus.mem_rdata <= dmem[bus.mem_addr[9:0]];
        end
    end

    // Reference model: transaction-level arithmetic, one grant at a time.
    typedef struct {
        int          due;
        int          port;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [1024];
    int          cyc = 0;
    int          free_cyc = 0;
    int          wen_cyc = -100;
    int          last = 1;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] b, h;
        b = w % 256;
        h = w % 65536;
        case (f3)
            3'd0:    ref_load = (b >= 128) ? b - 32'd256 : b;
            3'd1:    ref_load = (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    ref_load = b;
            3'd5:    ref_load = h;
            default: ref_load = w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] old, input logic [31:0] wd);
        case (f3)
            3'd0:    ref_store = (old / 256) * 256 + wd % 256;
            3'd1:    ref_store = (old / 65536) * 65536 + wd % 65536;
            default: ref_store = wd;
        endcase
    endfunction

    task automatic model_step();
        logic [1:0]  exp_rdy;
        int          g;
        logic [2:0]  f3;
        logic [31:0] a;
        logic        we, legal;
        exp_t        e;
        cyc++;
        exp_rdy = 2'b00;
        g = 0;
        if (cyc >= free_cyc && bus.req_valid != 2'b00) begin
            if (bus.req_valid == 2'b11) g = (RR_MODE && last == 0) ? 1 : 0;
            else                        g = (bus.req_valid == 2'b10) ? 1 : 0;
            exp_rdy = (g == 1) ? 2'b10 : 2'b01;
        end
        chk("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_rdy});
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("resp_valid", {30'd0, bus.resp_valid}, (q[0].port == 1) ? 32'd2 : 32'd1);
            chk("resp_err", {31'd0, bus.resp_err}, {31'd0, q[0].err});
            chk("resp_rdata", bus.resp_rdata, q[0].data);
            q.delete(0);
        end else begin
            chk("resp_quiet", {30'd0, bus.resp_valid}, 32'd0);
        end
        chk("mem_wen", {31'd0, bus.mem_wen}, (wen_cyc == cyc) ? 32'd1 : 32'd0);
        if (exp_rdy != 2'b00) begin
            f3 = bus.req_func3[g];
            a  = bus.req_addr[g];
            we = bus.req_we[g];
            last = g;
            legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(we && f3 >= 3'd4) && (a < 32'h0100_0000);
            e.port = g;
            if (!legal) begin
                e.due = cyc + 1; e.err = 1'b1; e.data = '0;
                free_cyc = cyc + 1;
            end else begin
                e.due = cyc + 3; e.err = 1'b0;
                free_cyc = cyc + 3;
                if (we) begin
                    ref_mem[a % 1024] = ref_store(f3, ref_mem[a % 1024], bus.req_wdata[g]);
                    e.data = '0;
                    wen_cyc = cyc + 1;
                end else begin
                    e.data = ref_load(f3, ref_mem[a % 1024]);
                end
            end
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (mem_clr) for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        if (rst) begin
            q.delete();
            free_cyc = 0;
            wen_cyc  = -100;
            last     = 1;
        end else begin
            model_step();
        end
    end

    task automatic do_txn(input int p, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic err, output logic [31:0] rd,
                          output int lat, output bit ok);
        int n;
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b1; bus.req_we[p] = we; bus.req_func3[p] = f3;
        bus.req_addr[p] = a; bus.req_wdata[p] = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready[p] && n < 20);
        ok = bus.req_ready[p];
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.resp_valid[p] && lat < 20);
        ok  = ok && bus.resp_valid[p];
        err = bus.resp_err;
        rd  = bus.resp_rdata;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},  {30'd0, bus.req_ready}, 32'd0);
        chk({tag, "_resp_valid"}, {30'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_resp_err"},   {31'd0, bus.resp_err}, 32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_mem_wen"},    {31'd0, bus.mem_wen}, 32'd0);
        chk({tag, "_mem_func3"},  {29'd0, bus.mem_func3}, 32'd0);
        chk({tag, "_mem_addr"},   bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"},  bus.mem_wdata, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t        tbl[16];
    logic        t_err;
    logic [31:0] t_rd;
    int          t_lat;
    bit          t_ok;
    int          grants[$];
    int          n;
    logic [1:0]  pend, acc;
    logic [2:0]  legal_f3[5];
    logic [2:0]  bad_f3[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, F3_LW,  32'd5,          32'hDEADBEEF, 1'b0, 32'h0,        3};
        tbl[1]  = '{1'b0, F3_LW,  32'd5,          32'h0,        1'b0, 32'hDEADBEEF, 3};
        tbl[2]  = '{1'b1, F3_LW,  32'd7,          32'h000000F0, 1'b0, 32'h0,        3};
        tbl[3]  = '{1'b0, F3_LB,  32'd7,          32'h0,        1'b0, 32'hFFFFFFF0, 3};
        tbl[4]  = '{1'b0, F3_LBU, 32'd7,          32'h0,        1'b0, 32'h000000F0, 3};
        tbl[5]  = '{1'b1, F3_LW,  32'd8,          32'h00008001, 1'b0, 32'h0,        3};
        tbl[6]  = '{1'b0, F3_LH,  32'd8,          32'h0,        1'b0, 32'hFFFF8001, 3};
        tbl[7]  = '{1'b0, F3_LHU, 32'd8,          32'h0,        1'b0, 32'h00008001, 3};
        tbl[8]  = '{1'b0, 3'b011, 32'd1,          32'h0,        1'b1, 32'h0,        1};
        tbl[9]  = '{1'b0, F3_LW,  32'h0100_0000,  32'h0,        1'b1, 32'h0,        1};
        tbl[10] = '{1'b1, F3_LBU, 32'd3,          32'h55,       1'b1, 32'h0,        1};
        tbl[11] = '{1'b1, F3_LW,  32'd9,          32'hFFFFFFFF, 1'b0, 32'h0,        3};
        tbl[12] = '{1'b1, F3_LH,  32'd9,          32'h12345678, 1'b0, 32'h0,        3};
        tbl[13] = '{1'b0, F3_LW,  32'd9,          32'h0,        1'b0, 32'hFFFF5678, 3};
        tbl[14] = '{1'b1, F3_LB,  32'd9,          32'h000000AB, 1'b0, 32'h0,        3};
        tbl[15] = '{1'b0, F3_LW,  32'd9,          32'h0,        1'b0, 32'hFFFF56AB, 3};
        legal_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        bad_f3   = '{3'b011, 3'b110, 3'b111};

        rst = 1'b1; mem_clr = 1'b1;
        bus.req_valid = '0; bus.req_we = '0; bus.req_func3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        @(negedge clk);
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; mem_clr = 1'b0;

        // Both ports hold valid: grant order after reset.
        @(posedge clk); #1;
        bus.req_valid = 2'b11; bus.req_we = 2'b00;
        bus.req_func3[0] = F3_LW; bus.req_func3[1] = F3_LW;
        bus.req_addr[0] = 32'd5; bus.req_addr[1] = 32'd7;
        n = 0;
        while (grants.size() < 4 && n < 40) begin
            @(negedge clk); n++;
            if (bus.req_ready != 2'b00) grants.push_back(bus.req_ready[1] ? 1 : 0);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        chk("grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk($sformatf("grant%0d", i), grants[i], RR_MODE ? (i % 2) : 0);
        repeat (4) @(posedge clk);

        for (int i = 0; i < 16; i++) begin
            do_txn(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, t_err, t_rd, t_lat, t_ok);
            chk($sformatf("tbl%0d_done", i), {31'd0, t_ok}, 32'd1);
            chk($sformatf("tbl%0d_err", i), {31'd0, t_err}, {31'd0, tbl[i].err});
            chk($sformatf("tbl%0d_rdata", i), t_rd, tbl[i].rd);
            chk($sformatf("tbl%0d_latency", i), t_lat, tbl[i].lat);
        end

        // Reset lands during ISSUE of a store: no response, store never reaches memory.
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b1; bus.req_we[0] = 1'b1; bus.req_func3[0] = F3_LW;
        bus.req_addr[0] = 32'd1000; bus.req_wdata[0] = 32'hA5A5A5A5;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready[0] && n < 20);
        chk("rst_accept", {31'd0, bus.req_ready[0]}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        chk("rst_issue_wen", {31'd0, bus.mem_wen}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_resp", {30'd0, bus.resp_valid}, 32'd0);
        end
        @(posedge clk); #1; rst = 1'b0;
        chk("midrst_no_write", dmem[1000], 32'd0);
        do_txn(0, 1'b0, F3_LW, 32'd5, 32'h0, t_err, t_rd, t_lat, t_ok);
        chk("post_rst_done", {31'd0, t_ok}, 32'd1);
        chk("post_rst_rdata", t_rd, 32'hDEADBEEF);
        chk("post_rst_latency", t_lat, 3);

        // Random traffic on both ports; the reference model checks every cycle.
        pend = 2'b00;
        for (int c = 0; c < 1400; c++) begin
            if (c >= 800 && pend == 2'b00) break;
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin pend[p] = 1'b0; bus.req_valid[p] = 1'b0; end
                if (!pend[p] && c < 800 && ($urandom % 3) == 0) begin
                    bus.req_we[p]    = ($urandom % 2) == 1;
                    bus.req_func3[p] = (($urandom % 10) < 8) ? legal_f3[$urandom % 5] : bad_f3[$urandom % 3];
                    bus.req_addr[p]  = (($urandom % 16) == 0) ? (32'h0100_0000 + ($urandom % 256)) : ($urandom % 512);
                    bus.req_wdata[p] = $urandom;
                    bus.req_valid[p] = 1'b1;
                    pend[p] = 1'b1;
                end
            end
        end
        chk("random_drain", {30'd0, pend}, 32'd0);
        bus.req_valid = 2'b00;
        repeat (6) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 24, word-index width of the shared data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-port request valid (port 0 = CPU load/store, port 1 = loader/debug).
REQ-005 req_ready  output  2  per-port accept strobe; a request transfers when valid and ready are both high at a rising edge.
REQ-006 req_we  input  2  per-port write flag.
REQ-007 req_func3  input  2x3  per-port access type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
REQ-008 req_addr  input  2x32  per-port word index.
REQ-009 req_wdata  input  2x32  per-port store data, low-aligned.
REQ-010 resp_valid  output  2  per-port one-cycle response strobe; there is no response back-pressure.
REQ-011 resp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-012 resp_err  output  1  response flags an illegal access.
REQ-013 mem_func3, mem_addr, mem_wdata, mem_wen  output  3/32/32/1  drive the shared data memory.
REQ-014 mem_rdata  input  32  memory read data, valid the cycle after the memory samples the address.

Function
REQ-015 States: IDLE, ISSUE, CAPTURE; exactly one request is outstanding at a time.
REQ-016 IDLE: if any req_valid is high, assert req_ready for the granted port only, latch its fields, and record the grant.
REQ-017 After latching, go to ISSUE if the request is legal; otherwise stay in IDLE and pulse resp_valid with resp_err=1 in the next cycle.
REQ-018 Illegal: func3 is 011, 110 or 111; or req_addr[31:ADDR_W] is nonzero; or req_we=1 with func3[2]=1.
REQ-019 ISSUE (one cycle): mem_addr = latched address, mem_wdata = latched data, mem_func3 = {1'b0, func3[1:0]}, mem_wen = latched we; then go to CAPTURE.
REQ-020 mem_wen is 0 in every state except ISSUE; the other mem outputs hold their last values.
REQ-021 CAPTURE (one cycle): register extended mem_rdata into resp_rdata, pulse resp_valid for the granted port next cycle, return to IDLE.
REQ-022 Extension: func3[2]=0 sign-extends from bit 7/15; func3[2]=1 zero-extends; lw passes through.
REQ-023 Latency: legal access, resp_valid in the 3rd cycle after the accept edge; illegal access, in the 1st.
REQ-024 IDLE may accept a new request in the same cycle resp_valid is high, giving back-to-back throughput of 1 access per 3 cycles.
REQ-025 req_ready is low in ISSUE and CAPTURE; requests arriving then wait while held valid.
REQ-026 At most one resp_valid bit is high in any cycle.

Reset
REQ-027 rst forces IDLE, and clears req_ready, resp_valid, resp_err, resp_rdata, mem_wen, mem_func3, mem_addr, mem_wdata and the last-grant register (set to port 1, so port 0 wins first).
REQ-028 rst asserted mid-access abandons the access with no response; a write already sampled by the memory is not undone.

Configuration
REQ-029 With DMEM_ARB_RR_EN defined: round-robin; on simultaneous requests, grant the port not granted last.
REQ-030 Without DMEM_ARB_RR_EN: fixed priority; port 0 always wins and the last-grant register is not implemented.

Structure
REQ-031 The shared package dmem_pkg holds the func3 encoding constants, the FSM state typedef and the port-index constants.
REQ-032 Load extension is the combinational sub-module dmem_load_ext (inputs func3 and raw data, output extended data).

Verification
REQ-033 Port 0: lw write, addr 5, wdata 0xDEADBEEF; then lw read, addr 5 -> mem_wen high exactly one cycle; read resp_rdata=0xDEADBEEF, 3 cycles after accept.
REQ-034 Memory word 0x000000F0 at addr 7: lb -> 0xFFFFFFF0; lbu -> 0x000000F0; lh of 0x00008001 -> 0xFFFF8001.
REQ-035 Both ports hold valid continuously with DMEM_ARB_RR_EN -> grants alternate 0,1,0,1; without the macro -> port 0 only.
REQ-036 func3=011 or addr 0x01000000 -> resp_err=1 next cycle; mem_wen never asserted.
REQ-037 rst asserted during ISSUE of a write -> no resp_valid; all outputs 0; next request is serviced normally.
